// File: rtl/phys_state_file.sv
// Physical register file, spec/arch valid bitmaps and committed flags; reads are combinational with CDB bypass.
// CDB/commit/flag writes land on the next edge; busy_o asks rename/issue to stall while draining after a mispredict.
module phys_state_file #(
  parameter int WORD_SIZE_P  = 16,
  parameter int NUM_PHYS_REG = 128,
  parameter int NUM_ARCH_REG = 16,
  parameter int NUM_CDB      = 4,
  parameter int NUM_READ     = 4,
  parameter int COMMIT_W     = 2,
  parameter int NUM_FLAGS    = 4,
  parameter int DRAIN_CYCLES = 3,
  localparam int PW    = $clog2(NUM_PHYS_REG),
  localparam int CDB_W = 1 + PW + WORD_SIZE_P
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [NUM_CDB-1:0][CDB_W-1:0]          cdb_i,
  input  logic [COMMIT_W-1:0]                    commit_valid_i,
  input  logic [COMMIT_W-1:0][PW-1:0]            commit_cl_i,
  input  logic [COMMIT_W-1:0][PW-1:0]            commit_set_i,
  input  logic [COMMIT_W-1:0]                    commit_flag_valid_i,
  input  logic [COMMIT_W-1:0][2*NUM_FLAGS-1:0]   commit_flag_i,
  input  logic                                   mispredict_i,
  input  logic [NUM_READ-1:0][PW-1:0]            rd_idx_i,
  output logic [NUM_READ-1:0]                    rd_valid_o,
  output logic [NUM_READ-1:0][WORD_SIZE_P-1:0]   rd_data_o,
  output logic [NUM_FLAGS-1:0]                   flag_o,
  output logic                                   busy_o,
  output logic                                   cdb_conflict_o
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [NUM_PHYS_REG-1:0] ARCH_INIT =
    {{(NUM_PHYS_REG-NUM_ARCH_REG){1'b0}}, {NUM_ARCH_REG{1'b1}}};

  // Each cdb_i lane is packed as {valid, dest, result}.
  typedef struct packed {
    logic                   valid;
    logic [PW-1:0]          dest;
    logic [WORD_SIZE_P-1:0] result;
  } cdb_t;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                                r_state;
  logic [CW-1:0]                         r_cnt;
  logic                                  r_busy;
  logic                                  r_conflict;
  logic [NUM_FLAGS-1:0]                  r_flag;
  logic [NUM_PHYS_REG-1:0]               r_valid;
  logic [NUM_PHYS_REG-1:0]               r_arch;
  logic [NUM_PHYS_REG-1:0][WORD_SIZE_P-1:0] r_reg;

  cdb_t                    w_cdb [NUM_CDB];
  logic                    w_drain;
  logic [NUM_PHYS_REG-1:0] w_valid_nxt;
  logic [NUM_PHYS_REG-1:0] w_arch_nxt;
  logic [NUM_FLAGS-1:0]    w_flag_nxt;
  logic                    w_conflict;
  logic [NUM_FLAGS-1:0]    w_mask;
  logic [NUM_FLAGS-1:0]    w_val;

  assign w_drain        = (r_state == S_DRAIN);
  assign busy_o         = r_busy;
  assign flag_o         = r_flag;
  assign cdb_conflict_o = r_conflict;

  always_comb begin
    for (int l = 0; l < NUM_CDB; l++) w_cdb[l] = cdb_t'(cdb_i[l]);
  end

  // Ascending lane scan so the highest matching lane overrides the bypass.
  always_comb begin
    for (int p = 0; p < NUM_READ; p++) begin
      rd_valid_o[p] = r_valid[rd_idx_i[p]];
      rd_data_o[p]  = r_reg[rd_idx_i[p]];
      if (!w_drain) begin
        for (int l = 0; l < NUM_CDB; l++) begin
          if (w_cdb[l].valid && (w_cdb[l].dest == rd_idx_i[p])) begin
            rd_valid_o[p] = 1'b1;
            rd_data_o[p]  = w_cdb[l].result;
          end
        end
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_arch_nxt  = r_arch;
    w_flag_nxt  = r_flag;
    w_conflict  = 1'b0;
    w_mask      = '0;
    w_val       = '0;
    if (!w_drain) begin
      for (int l = 0; l < NUM_CDB; l++) begin
        if (w_cdb[l].valid) w_valid_nxt[w_cdb[l].dest] = 1'b1;
        for (int k = l + 1; k < NUM_CDB; k++) begin
          if (w_cdb[l].valid && w_cdb[k].valid && (w_cdb[l].dest == w_cdb[k].dest))
            w_conflict = 1'b1;
        end
      end
    end
    // Commit clears come after CDB sets, so a same-cycle free wins.
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_valid_i[c]) begin
        w_valid_nxt[commit_cl_i[c]] = 1'b0;
        w_arch_nxt[commit_cl_i[c]]  = 1'b0;
        w_arch_nxt[commit_set_i[c]] = 1'b1;
      end
      if (commit_flag_valid_i[c]) begin
        w_mask     = commit_flag_i[c][2*NUM_FLAGS-1:NUM_FLAGS];
        w_val      = commit_flag_i[c][NUM_FLAGS-1:0];
        w_flag_nxt = (w_mask & w_val) | (~w_mask & w_flag_nxt);
      end
    end
    if (mispredict_i) w_valid_nxt = w_arch_nxt;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_reg      <= '0;
      r_valid    <= ARCH_INIT;
      r_arch     <= ARCH_INIT;
      r_flag     <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (!w_drain) begin
        for (int l = 0; l < NUM_CDB; l++) begin
          if (w_cdb[l].valid) r_reg[w_cdb[l].dest] <= w_cdb[l].result;
        end
      end
      r_valid    <= w_valid_nxt;
      r_arch     <= w_arch_nxt;
      r_flag     <= w_flag_nxt;
      r_conflict <= r_conflict | w_conflict;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mispredict_i) begin
            r_state <= S_DRAIN;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (mispredict_i) begin
            r_cnt <= CNT_LOAD;
          end else if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phys_state_file.sv
// Randomised and directed stimulus for phys_state_file; a behavioural model pushes
// per-cycle expected outputs into a queue that a negedge monitor pops and compares.
module tb_phys_state_file;
  localparam int W  = 16;
  localparam int NP = 128;
  localparam int NA = 16;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int CW = 2;
  localparam int NF = 4;
  localparam int DC = 3;
  localparam int PW = 7;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic [NC-1:0][1+PW+W-1:0] cdb_bus;
  logic          cdb_v [NC];
  logic [PW-1:0] cdb_d [NC];
  logic [W-1:0]  cdb_r [NC];
  logic [CW-1:0]          commit_valid;
  logic [CW-1:0][PW-1:0]  commit_cl;
  logic [CW-1:0][PW-1:0]  commit_set;
  logic [CW-1:0]          commit_flag_valid;
  logic [CW-1:0][2*NF-1:0] commit_flag;
  logic                   mispredict;
  logic [NR-1:0][PW-1:0]  rd_idx;
  logic [NR-1:0]          rd_valid;
  logic [NR-1:0][W-1:0]   rd_data;
  logic [NF-1:0]          flag;
  logic                   busy;
  logic                   conflict;

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int l = 0; l < NC; l++) cdb_bus[l] = {cdb_v[l], cdb_d[l], cdb_r[l]};
  end

  phys_state_file dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .cdb_i(cdb_bus),
    .commit_valid_i(commit_valid), .commit_cl_i(commit_cl), .commit_set_i(commit_set),
    .commit_flag_valid_i(commit_flag_valid), .commit_flag_i(commit_flag),
    .mispredict_i(mispredict), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid),
    .rd_data_o(rd_data), .flag_o(flag), .busy_o(busy), .cdb_conflict_o(conflict)
  );

  typedef struct packed {
    logic [NR-1:0]        v;
    logic [NR-1:0][W-1:0] d;
    logic [NF-1:0]        flag;
    logic                 busy;
    logic                 conf;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [W-1:0] m_reg [NP];
  bit           m_valid [NP];
  bit           m_arch [NP];
  logic [NF-1:0] m_flag;
  bit           m_conf;
  int           m_drain_left;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_reg[i] = '0;
      m_valid[i] = (i < NA);
      m_arch[i] = (i < NA);
    end
    m_flag = '0;
    m_conf = 1'b0;
    m_drain_left = 0;
  endtask

  task automatic idle_inputs();
    for (int l = 0; l < NC; l++) begin
      cdb_v[l] = 1'b0; cdb_d[l] = '0; cdb_r[l] = '0;
    end
    commit_valid = '0; commit_cl = '0; commit_set = '0;
    commit_flag_valid = '0; commit_flag = '0;
    mispredict = 1'b0;
    rd_idx = '0;
  endtask

  // Predict this cycle's outputs, queue them, then advance the model by one edge.
  task automatic step();
    exp_t e;
    bit draining;
    logic [NF-1:0] mk, vl;
    draining = (m_drain_left > 0);
    e.busy = draining;
    e.conf = m_conf;
    e.flag = m_flag;
    for (int p = 0; p < NR; p++) begin
      e.v[p] = m_valid[rd_idx[p]];
      e.d[p] = m_reg[rd_idx[p]];
      if (!draining)
        for (int l = 0; l < NC; l++)
          if (cdb_v[l] && cdb_d[l] == rd_idx[p]) begin
            e.v[p] = 1'b1;
            e.d[p] = cdb_r[l];
          end
    end
    sb.push_back(e);
    if (!draining) begin
      for (int l = 0; l < NC; l++) begin
        if (cdb_v[l]) begin
          m_reg[cdb_d[l]] = cdb_r[l];
          m_valid[cdb_d[l]] = 1'b1;
        end
        for (int k = 0; k < l; k++)
          if (cdb_v[l] && cdb_v[k] && cdb_d[l] == cdb_d[k]) m_conf = 1'b1;
      end
    end
    for (int c = 0; c < CW; c++) begin
      if (commit_valid[c]) begin
        m_valid[commit_cl[c]] = 1'b0;
        m_arch[commit_cl[c]] = 1'b0;
        m_arch[commit_set[c]] = 1'b1;
      end
      if (commit_flag_valid[c]) begin
        mk = commit_flag[c][2*NF-1:NF];
        vl = commit_flag[c][NF-1:0];
        m_flag = (mk & vl) | (~mk & m_flag);
      end
    end
    if (mispredict) begin
      for (int i = 0; i < NP; i++) m_valid[i] = m_arch[i];
      m_drain_left = DC;
    end else if (m_drain_left > 0) begin
      m_drain_left--;
    end
    @(posedge clk_i); #1;
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int p = 0; p < NR; p++) begin
        check($sformatf("rd_valid[%0d]", p), 32'(rd_valid[p]), 32'(e.v[p]));
        check($sformatf("rd_data[%0d]", p), 32'(rd_data[p]), 32'(e.d[p]));
      end
      check("flag_o", 32'(flag), 32'(e.flag));
      check("busy_o", 32'(busy), 32'(e.busy));
      check("cdb_conflict_o", 32'(conflict), 32'(e.conf));
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    reset_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Reset state: arch reg 5 valid, reg 20 not
    rd_idx[0] = 7'd5; rd_idx[1] = 7'd20; step();

    // Single CDB lane bypass then stored read
    idle_inputs();
    cdb_v[1] = 1'b1; cdb_d[1] = 7'd40; cdb_r[1] = 16'hBEEF; rd_idx[0] = 7'd40; step();
    idle_inputs(); rd_idx[0] = 7'd40; step();

    // Conflicting lanes 0 and 3 on dest 50
    idle_inputs();
    cdb_v[0] = 1'b1; cdb_d[0] = 7'd50; cdb_r[0] = 16'h1111;
    cdb_v[3] = 1'b1; cdb_d[3] = 7'd50; cdb_r[3] = 16'h2222;
    rd_idx[2] = 7'd50; step();
    idle_inputs(); rd_idx[2] = 7'd50; step();

    // Chained commits, then rollback exposes valid_arch
    idle_inputs();
    commit_valid = 2'b11;
    commit_cl[0] = 7'd3;  commit_set[0] = 7'd40;
    commit_cl[1] = 7'd40; commit_set[1] = 7'd41;
    commit_flag_valid = 2'b11;
    commit_flag[0] = 8'b0011_0001; commit_flag[1] = 8'b0010_0010;
    step();
    idle_inputs(); rd_idx[0] = 7'd3; mispredict = 1'b1; step();
    idle_inputs(); rd_idx[0] = 7'd40; rd_idx[1] = 7'd41; rd_idx[2] = 7'd3; rd_idx[3] = 7'd50;
    repeat (4) step();

    // Speculative-only reg 60, mispredict, blocked CDB in DRAIN, reset mid-DRAIN
    idle_inputs(); cdb_v[2] = 1'b1; cdb_d[2] = 7'd60; cdb_r[2] = 16'h6060; step();
    idle_inputs(); rd_idx[0] = 7'd60; mispredict = 1'b1; step();
    idle_inputs(); rd_idx[0] = 7'd60; cdb_v[0] = 1'b1; cdb_d[0] = 7'd60; cdb_r[0] = 16'hDEAD; step();
    idle_inputs(); rd_idx[0] = 7'd60; step();
    check("busy_before_reset", 32'(busy), 32'(m_drain_left > 0));
    reset_n_i = 1'b0;
    #1;
    check("busy_async_reset", 32'(busy), 32'd0);
    check("conflict_async_reset", 32'(conflict), 32'd0);
    check("flag_async_reset", 32'(flag), 32'd0);
    model_reset();
    @(negedge clk_i); reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle_inputs();
      for (int l = 0; l < NC; l++) begin
        cdb_v[l] = ($urandom_range(0, 1) == 1);
        cdb_d[l] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, NP - 1)) : 7'($urandom_range(32, 47));
        cdb_r[l] = 16'($urandom);
      end
      for (int p = 0; p < NR; p++)
        rd_idx[p] = ($urandom_range(0, 2) == 0) ? cdb_d[$urandom_range(0, NC - 1)]
                                                : 7'($urandom_range(0, 63));
      for (int c = 0; c < CW; c++) begin
        commit_valid[c] = ($urandom_range(0, 3) == 0);
        commit_cl[c] = 7'($urandom_range(0, 63));
        commit_set[c] = 7'($urandom_range(0, 63));
        commit_flag_valid[c] = ($urandom_range(0, 2) == 0);
        commit_flag[c] = 8'($urandom);
      end
      mispredict = ($urandom_range(0, 19) == 0);
      step();
    end

    idle_inputs();
    @(negedge clk_i); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phys_state_file.md
# phys_state_file

Parametrised successor to the single-commit physical register state block. It holds the physical register data, speculative and architectural valid bitmaps, and the committed condition flags. It adds N-wide read, CDB and commit ports, same-cycle CDB bypass on every read port, and a post-mispredict drain state that blocks late broadcasts from squashed producers. It sits between the CDB/functional units, the issue stage (operand reads) and the ROB commit logic.

## Interface
- WORD_SIZE_P, 16, data word width
- NUM_PHYS_REG, 128, physical registers; index width PW = $clog2(NUM_PHYS_REG)
- NUM_ARCH_REG, 16, registers 0..NUM_ARCH_REG-1 valid out of reset
- NUM_CDB, 4, CDB broadcast lanes
- NUM_READ, 4, operand read ports
- COMMIT_W, 2, commit lanes per cycle
- NUM_FLAGS, 4, condition flag count
- DRAIN_CYCLES, 3, cycles spent in DRAIN after a mispredict (≥1)

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
  - clk_i, in, 1, clock
  - reset_n_i, in, 1, asynchronous active-low reset
- cdb_i, in, CDB_t [NUM_CDB], fields valid/dest/result
- commit_valid_i, in, [COMMIT_W], lane valid
- commit_cl_i, in, [COMMIT_W][PW], physical register freed by the lane
- commit_set_i, in, [COMMIT_W][PW], physical register made architectural by the lane
- commit_flag_valid_i, in, [COMMIT_W], lane carries a flag update
- commit_flag_i, in, [COMMIT_W][2*NUM_FLAGS], {mask, value}
- mispredict_i, in, 1, roll speculative valids back to architectural
- rd_idx_i, in, [NUM_READ][PW], read index
- rd_valid_o, out, [NUM_READ], operand ready
- rd_data_o, out, [NUM_READ][WORD_SIZE_P], operand data
- flag_o, out, NUM_FLAGS, committed flags
- busy_o, out, 1, high in DRAIN; rename/issue must stall
- cdb_conflict_o, out, 1, sticky: two valid CDB lanes hit the same dest in one cycle

## Operation
- Reset: all data 0; valid and valid_arch hold 1 in bits [NUM_ARCH_REG-1:0] and 0 elsewhere; flags 0; state IDLE; busy_o 0; cdb_conflict_o 0.
- Reads are combinational. rd_valid_o[p] = valid[idx] and rd_data_o[p] = reg[idx], overridden by any valid CDB lane whose dest matches idx. The highest-index lane wins. Bypass is disabled in DRAIN.
- Next-state order within a cycle:
  1. CDB writes set data and valid. Suppressed in DRAIN.
  2. Commit lanes are applied lane 0 upward. Each valid lane clears valid[cl] and valid_arch[cl], then sets valid_arch[set].
  3. If mispredict_i is high, valid_next = valid_arch_next, which includes this cycle's commits.
- On a CDB write conflict (same dest, both lanes valid), the highest lane's data wins and cdb_conflict_o is set. It clears only on reset.
- Flags are applied lane 0 upward: flag = (mask & value) | (~mask & flag). flag_o is the registered value, with no bypass.
- FSM states:
  - IDLE: on mispredict_i, go to DRAIN and load cnt = DRAIN_CYCLES-1.
  - DRAIN: busy_o = 1. Each cycle, if cnt == 0 go to IDLE, else decrement cnt. A mispredict_i in DRAIN reloads cnt = DRAIN_CYCLES-1 and applies the rollback again.
- Commits and flag updates are still honoured in DRAIN.
- A commit whose cl equals a same-cycle CDB dest leaves valid = 0, because the clear wins.

## Timing
- Read: 0-cycle combinational, including CDB bypass.
- CDB write: visible in the register array on the next edge.
- Commit and flag writes: visible on flag_o and valid next cycle.
- Mispredict in cycle T: the rollback state is visible at T+1. busy_o is high for T+1 .. T+DRAIN_CYCLES and low at T+DRAIN_CYCLES+1.
- Reset assertion clears state immediately, mid-DRAIN included. The first edge after deassertion is a normal IDLE cycle.

## Test plan
- Reset, then read idx 5 and idx 20 -> rd_valid = 1 and 0, data 0; flag_o = 0; busy_o = 0.
- CDB lane 1 {dest 40, result 16'hBEEF} with port 0 reading 40 in the same cycle -> rd_valid 1, data BEEF. Next cycle, with no CDB, the same read still gives BEEF.
- Lanes 0 and 3 both target dest 50 (16'h1111, 16'h2222) -> read returns 2222 (same cycle and stored), and cdb_conflict_o = 1 from the next cycle onward.
- Commit lane 0 {cl 3, set 40} and lane 1 {cl 40, set 41} in one cycle -> valid_arch[40] = 0, valid_arch[41] = 1, valid[3] = 0.
- Flag lanes: lane 0 {mask 4'b0011, val 4'b0001}, lane 1 {mask 4'b0010, val 4'b0010} -> flag_o = 4'b0011 next cycle.
- Reg 60 is valid speculatively only, then mispredict -> valid[60] = 0 next cycle and busy_o high for 3 cycles. A CDB to dest 60 during DRAIN -> read of 60 returns valid 0 and no bypass. Asserting reset_n_i low mid-DRAIN -> busy_o is 0 immediately.
